// File: rtl/pipe_sel_reg_if.sv
// Select/delay-line bundle: decode-side controls in, staged selection out.
interface pipe_sel_reg_if #(
   parameter int WIDTH = 5,
   parameter int N     = 3,
   parameter int SELW  = 2
);
   logic                 stall;
   logic                 flush;
   logic                 in_valid;
   logic [SELW-1:0]      sel;
   logic [N*WIDTH-1:0]   din;
   logic [WIDTH-1:0]     dout_comb;
   logic [WIDTH-1:0]     dout;
   logic                 dout_valid;
   logic                 bad_sel;
   logic [7:0]           bad_cnt;

   modport master (
      output stall, flush, in_valid, sel, din,
      input  dout_comb, dout, dout_valid, bad_sel, bad_cnt
   );

   modport slave (
      input  stall, flush, in_valid, sel, din,
      output dout_comb, dout, dout_valid, bad_sel, bad_cnt
   );
endinterface

// File: rtl/pipe_sel_reg.sv
// N-way select into a DEPTH-stage delay line with stall, flush,
// valid tracking and sticky/saturating out-of-range select flags.
module pipe_sel_reg #(
   parameter int             WIDTH     = 5,
   parameter int             N         = 3,
   parameter int             SELW      = 2,
   parameter int             DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic           clk,
   input logic           reset,
   pipe_sel_reg_if.slave sb
);
   logic [WIDTH-1:0] w_sel;
   logic             w_oor;
   logic             w_load;
   logic             w_evt;

   logic [WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic             r_bad;
   logic [7:0]       r_cnt;

   // Out-of-range selects fall back to input 0.
   always_comb begin
      w_sel = sb.din[0 +: WIDTH];
      for (int k = 1; k < N; k++) begin
         if (sb.sel == SELW'(k)) w_sel = sb.din[k*WIDTH +: WIDTH];
      end
   end

   assign w_oor  = ({1'b0, sb.sel} >= (SELW+1)'(N));
   assign w_load = !sb.flush && !sb.stall;
   assign w_evt  = w_load && sb.in_valid && w_oor;

   always_ff @(posedge clk) begin
      if (reset || sb.flush) begin
         for (int i = 0; i < DEPTH; i++) r_data[i] <= RESET_VAL;
         r_valid <= '0;
      end else if (!sb.stall) begin
         r_data[0]  <= w_sel;
         r_valid[0] <= sb.in_valid;
         for (int i = 1; i < DEPTH; i++) begin
            r_data[i]  <= r_data[i-1];
            r_valid[i] <= r_valid[i-1];
         end
      end
   end

   // Flags survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bad <= 1'b0;
         r_cnt <= 8'd0;
      end else if (w_evt) begin
         r_bad <= 1'b1;
         if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      end
   end

   assign sb.dout_comb  = w_sel;
   assign sb.dout       = r_data[DEPTH-1];
   assign sb.dout_valid = r_valid[DEPTH-1];
   assign sb.bad_sel    = r_bad;
   assign sb.bad_cnt    = r_cnt;
endmodule
